// File: rtl/avmm_pr_arbiter_if.sv
// Avalon-MM command/response bundle between the arbiter and the shared
// downstream fabric port. The arbiter drives it through the master modport.
interface avmm_pr_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output writedata,
    output write,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  writedata,
    input  write,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/avmm_pr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between NUM_REQ
// partial-reconfiguration regions. Only one transaction is outstanding at a
// time; frozen regions are masked from arbitration and read returns are
// bounded by a timeout so a dead slave cannot lock the fabric port.
module avmm_pr_arbiter #(
  parameter int                NUM_REQ        = 2,
  parameter int                ADDR_W         = 20,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
  localparam int               GNT_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  input  logic [NUM_REQ-1:0]        freeze,
  avmm_pr_arbiter_if.master         m,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  // Counter is one bit wider than needed so TIMEOUT_CYCLES-1 always fits.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t            state_reg;
  logic [GNT_W-1:0]  last_grant_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;

  logic [NUM_REQ-1:0] valid;
  logic               any_valid;
  logic [GNT_W-1:0]   sel_next;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  // Unpack the per-region command buses and mask frozen regions.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_region
      assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_writedata[gi*DATA_W +: DATA_W];
      assign valid[gi]     = (req_read[gi] | req_write[gi]) & ~freeze[gi];
    end
  endgenerate

  // Round-robin pick: first valid region searching upward from last_grant+1.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    sel_next  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_valid && valid[GNT_W'(idx)]) begin
        any_valid = 1'b1;
        sel_next  = GNT_W'(idx);
      end
    end
  end

  // Accept strobe: only the selected region is released, and only in IDLE.
  // Held stalled while reset is asserted so nothing is accepted then.
  always_comb begin
    req_waitrequest = '1;
    if (rst && (state_reg == IDLE) && any_valid) begin
      req_waitrequest[sel_next] = 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);

  // Main controller: arbitration, downstream command hold, read return/timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      last_grant_reg    <= GNT_W'(NUM_REQ - 1);
      tmo_cnt_reg       <= '0;
      grant_id          <= '0;
      m.address         <= '0;
      m.writedata       <= '0;
      m.write           <= 1'b0;
      m.read            <= 1'b0;
      req_readdata      <= '0;
      req_readdatavalid <= '0;
      timeout_err       <= 1'b0;
    end else begin
      req_readdatavalid <= '0;
      timeout_err       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_id       <= sel_next;
            last_grant_reg <= sel_next;
            m.address      <= addr_arr[sel_next];
            m.writedata    <= wdata_arr[sel_next];
            // A region asserting read and write together is treated as a write.
            m.write        <= req_write[sel_next];
            m.read         <= req_read[sel_next] & ~req_write[sel_next];
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          // The command cannot be retracted once presented, so freeze is
          // ignored here; hold everything until the slave accepts.
          if (!m.waitrequest) begin
            m.write <= 1'b0;
            m.read  <= 1'b0;
            if (m.write) begin
              state_reg <= IDLE;
            end else begin
              tmo_cnt_reg <= '0;
              state_reg   <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (m.readdatavalid) begin
            // Real data wins over a coincident timeout.
            req_readdata                <= m.readdata;
            req_readdatavalid[grant_id] <= ~freeze[grant_id];
            state_reg                   <= IDLE;
          end else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_readdata                <= TIMEOUT_DATA;
            req_readdatavalid[grant_id] <= ~freeze[grant_id];
            timeout_err                 <= 1'b1;
            state_reg                   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_pr_arbiter.sv
// Directed self-checking bench for avmm_pr_arbiter (2 regions, short timeout).
module tb_avmm_pr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int TMO     = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic [NUM_REQ-1:0]        freeze;
  logic [0:0]                grant_id;
  logic                      busy;
  logic                      timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avmm_pr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avmm_pr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_read(req_read),
    .req_write(req_write),
    .req_address(req_address),
    .req_writedata(req_writedata),
    .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .freeze(freeze),
    .m(bus),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic clear_inputs();
    req_read          = '0;
    req_write         = '0;
    freeze            = '0;
    bus.waitrequest   = 1'b0;
    bus.readdata      = '0;
    bus.readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    req_address   = '0;
    req_writedata = '0;
    req_write     = 2'b01;
    @(negedge clk);
    checks++; if (req_waitrequest !== 2'b11) begin errors++; $display("FAIL reset_waitrequest: got %b expected 11", req_waitrequest); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.write !== 1'b0 || bus.read !== 1'b0) begin errors++; $display("FAIL reset_m_cmd: got wr=%b rd=%b expected 0 0", bus.write, bus.read); end
    checks++; if (bus.address !== 20'h0 || bus.writedata !== 32'h0) begin errors++; $display("FAIL reset_m_bus: got addr=%h wd=%h expected 0 0", bus.address, bus.writedata); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (req_readdatavalid !== 2'b00 || timeout_err !== 1'b0 || req_readdata !== 32'h0) begin errors++; $display("FAIL reset_resp: got rdv=%b te=%b rd=%h expected 00 0 0", req_readdatavalid, timeout_err, req_readdata); end
    @(posedge clk); #1;
    req_write = '0;
    rst = 1'b1;
    $display("tb: reset state checked");
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    req_write = 2'b01;
    req_address[0 +: ADDR_W]   = 20'h00010;
    req_writedata[0 +: DATA_W] = 32'h12345678;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (req_waitrequest !== 2'b10) begin errors++; $display("FAIL write_accept: got %b expected 10", req_waitrequest); end
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL write_early: got m_write=%b expected 0", bus.write); end
    @(posedge clk); #1;
    req_write = '0;
    @(negedge clk);
    checks++; if (bus.write !== 1'b1) begin errors++; $display("FAIL write_issue: got m_write=%b expected 1", bus.write); end
    checks++; if (bus.address !== 20'h00010 || bus.writedata !== 32'h12345678) begin errors++; $display("FAIL write_bus: got addr=%h wd=%h expected 00010 12345678", bus.address, bus.writedata); end
    checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL write_owner: got gnt=%0d busy=%b expected 0 1", grant_id, busy); end
    checks++; if (req_waitrequest !== 2'b11) begin errors++; $display("FAIL write_stall: got %b expected 11", req_waitrequest); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.write !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_done: got m_write=%b busy=%b expected 0 0", bus.write, busy); end
    $display("tb: single write region0 addr 00010 data 12345678");
  endtask

  task automatic test_round_robin();
    int          exp_g;
    int          grants;
    logic [1:0]  exp_wr;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    req_address   = {20'h00200, 20'h00100};
    req_writedata = {32'hBBBB0001, 32'hAAAA0000};
    req_write     = 2'b11;
    exp_g  = 0;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!busy) begin
        exp_wr = (exp_g == 0) ? 2'b10 : 2'b01;
        checks++; if (req_waitrequest !== exp_wr) begin errors++; $display("FAIL rr_accept: cycle %0d got %b expected %b", i, req_waitrequest, exp_wr); end
      end
      if (bus.write) begin
        checks++; if (grant_id !== exp_g[0]) begin errors++; $display("FAIL rr_grant: got %0d expected %0d", grant_id, exp_g); end
        checks++; if (bus.writedata !== ((exp_g == 0) ? 32'hAAAA0000 : 32'hBBBB0001)) begin errors++; $display("FAIL rr_data: got %h for region %0d", bus.writedata, exp_g); end
        $display("tb: round-robin write granted to region %0d", grant_id);
        exp_g  = 1 - exp_g;
        grants = grants + 1;
      end
    end
    checks++; if (grants !== 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", grants); end
    @(posedge clk); #1;
    req_write = '0;
  endtask

  task automatic test_read_stall();
    int   rd_high;
    logic te_seen;
    @(posedge clk); #1;
    req_read = 2'b10;
    req_address[ADDR_W +: ADDR_W] = 20'h0FFFC;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    checks++; if (req_waitrequest !== 2'b01) begin errors++; $display("FAIL rd_accept: got %b expected 01", req_waitrequest); end
    rd_high = 0;
    te_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      req_read          = '0;
      bus.waitrequest   = (i < 3);
      bus.readdatavalid = (i == 8);
      bus.readdata      = (i == 8) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      if (timeout_err) te_seen = 1'b1;
      if (bus.read) begin
        rd_high = rd_high + 1;
        checks++; if (bus.address !== 20'h0FFFC) begin errors++; $display("FAIL rd_addr: got %h expected 0FFFC", bus.address); end
      end
      if (i == 9) begin
        checks++; if (req_readdatavalid !== 2'b10) begin errors++; $display("FAIL rd_valid: got %b expected 10", req_readdatavalid); end
        checks++; if (req_readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data: got %h expected cafef00d", req_readdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got busy=%b expected 0", busy); end
      end else begin
        checks++; if (req_readdatavalid !== 2'b00) begin errors++; $display("FAIL rd_novalid: cycle %0d got %b expected 00", i, req_readdatavalid); end
      end
    end
    checks++; if (rd_high !== 4) begin errors++; $display("FAIL rd_hold: got m_read high %0d cycles expected 4", rd_high); end
    checks++; if (te_seen !== 1'b0) begin errors++; $display("FAIL rd_timeout_err: got pulse expected none"); end
    $display("tb: read region1 addr 0FFFC returned %h", req_readdata);
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    req_read = 2'b01;
    req_address[0 +: ADDR_W] = 20'h00ABC;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (req_waitrequest !== 2'b10) begin errors++; $display("FAIL to_accept: got %b expected 10", req_waitrequest); end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      req_read          = '0;
      bus.readdatavalid = (i == 20);
      bus.readdata      = (i == 20) ? 32'h11111111 : 32'h0;
      @(negedge clk);
      if (i == 17) begin
        checks++; if (req_readdatavalid !== 2'b01) begin errors++; $display("FAIL to_valid: got %b expected 01", req_readdatavalid); end
        checks++; if (req_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data: got %h expected deadbeef", req_readdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", timeout_err); end
      end else begin
        checks++; if (req_readdatavalid !== 2'b00 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_quiet: cycle %0d got rdv=%b te=%b expected 00 0", i, req_readdatavalid, timeout_err); end
      end
      checks++; if (busy !== (i <= 16)) begin errors++; $display("FAIL to_busy: cycle %0d got %b expected %b", i, busy, (i <= 16)); end
    end
    checks++; if (req_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_stray: got %h expected deadbeef", req_readdata); end
    $display("tb: read region0 timed out, returned %h", req_readdata);
  endtask

  task automatic test_timeout_race();
    @(posedge clk); #1;
    req_read = 2'b10;
    req_address[ADDR_W +: ADDR_W] = 20'h00123;
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      req_read          = '0;
      bus.readdatavalid = (i == 16);
      bus.readdata      = (i == 16) ? 32'h5A5A5A5A : 32'h0;
      @(negedge clk);
      if (i == 17) begin
        checks++; if (req_readdatavalid !== 2'b10) begin errors++; $display("FAIL race_valid: got %b expected 10", req_readdatavalid); end
        checks++; if (req_readdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL race_data: got %h expected 5a5a5a5a", req_readdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_err: got %b expected 0", timeout_err); end
      end
    end
    $display("tb: read region1 data at timeout edge returned %h", req_readdata);
  endtask

  task automatic test_freeze();
    int grants;
    @(posedge clk); #1;
    freeze    = 2'b01;
    req_write = 2'b11;
    grants    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (req_waitrequest[0] !== 1'b1) begin errors++; $display("FAIL frz_accept0: cycle %0d got %b expected 1", i, req_waitrequest[0]); end
      if (bus.write) begin
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL frz_grant: got %0d expected 1", grant_id); end
        grants = grants + 1;
      end
    end
    checks++; if (grants !== 4) begin errors++; $display("FAIL frz_count: got %0d grants expected 4", grants); end
    $display("tb: frozen region0 skipped, region1 granted %0d times", grants);
    @(posedge clk); #1;
    req_write = '0;
    freeze    = '0;
    @(posedge clk); #1;
    req_read = 2'b01;
    req_address[0 +: ADDR_W] = 20'h00055;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_read          = '0;
      freeze            = (i >= 2) ? 2'b01 : 2'b00;
      bus.readdatavalid = (i == 4);
      bus.readdata      = (i == 4) ? 32'h77777777 : 32'h0;
      @(negedge clk);
      checks++; if (req_readdatavalid !== 2'b00 || timeout_err !== 1'b0) begin errors++; $display("FAIL frz_rd_quiet: cycle %0d got rdv=%b te=%b expected 00 0", i, req_readdatavalid, timeout_err); end
      if (i == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frz_rd_idle: got busy=%b expected 0", busy); end
      end
    end
    @(posedge clk); #1;
    freeze = '0;
    $display("tb: read region0 frozen mid-wait, response dropped");
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    req_read = 2'b10;
    req_address[ADDR_W +: ADDR_W] = 20'h00333;
    bus.waitrequest = 1'b0;
    @(posedge clk); #1;
    req_read = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.read !== 1'b0 || bus.address !== 20'h0) begin errors++; $display("FAIL rst_async: got busy=%b rd=%b addr=%h expected 0 0 0", busy, bus.read, bus.address); end
    checks++; if (req_waitrequest !== 2'b11 || grant_id !== 1'b0) begin errors++; $display("FAIL rst_async_ctl: got wr=%b gnt=%0d expected 11 0", req_waitrequest, grant_id); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req_write = 2'b10;
    req_address[ADDR_W +: ADDR_W]   = 20'h00444;
    req_writedata[DATA_W +: DATA_W] = 32'h0BADF00D;
    @(negedge clk);
    checks++; if (req_waitrequest !== 2'b01) begin errors++; $display("FAIL rst_next_accept: got %b expected 01", req_waitrequest); end
    @(posedge clk); #1;
    req_write = '0;
    @(negedge clk);
    checks++; if (bus.write !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL rst_next_issue: got wr=%b gnt=%0d expected 1 1", bus.write, grant_id); end
    checks++; if (bus.address !== 20'h00444 || bus.writedata !== 32'h0BADF00D) begin errors++; $display("FAIL rst_next_bus: got addr=%h wd=%h expected 00444 0badf00d", bus.address, bus.writedata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_next_done: got busy=%b expected 0", busy); end
    $display("tb: reset during read wait, next write region1 accepted");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_stall();
    test_timeout();
    test_timeout_race();
    test_freeze();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
